// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants and types for the AES byte packer
//
// Contents:
//   AES_BLOCK_BITS / AES_BLOCK_BYTES : block geometry (128 bits, 16 bytes)
//   AES_PAD_FULL                     : byte value of a full PKCS#7 pad block
//   packer_state_t                   : packer FSM states (FILL, PADBLK)
//   lane_lsb()                       : bit offset of byte lane k within a block
package aes_pkg;

    localparam int         AES_BLOCK_BITS  = 128;
    localparam int         AES_BLOCK_BYTES = 16;
    localparam logic [7:0] AES_PAD_FULL    = 8'h10;

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        PADBLK = 1'b1
    } packer_state_t;

    // Byte k lives in bits [127-8k -: 8], so its LSB is 8*(15-k).
    // For a 4-bit k, 15-k is simply ~k.
    function automatic logic [6:0] lane_lsb(input logic [3:0] idx);
        return {~idx, 3'b000};
    endfunction

endpackage

// File: rtl/aes_byte_packer_if.sv
// rtl/aes_byte_packer_if.sv - byte input and block output handshake bundle
//
// Signals:
//   in_data[7:0], in_valid, in_last, in_ready     : byte stream into the packer
//   blk_data[127:0], blk_valid, blk_ready,
//   blk_last, blk_nbytes[4:0]                     : block stream out of the packer
// Modports:
//   slave  : packer side (consumes bytes, produces blocks)
//   master : environment side (produces bytes, consumes blocks)
interface aes_byte_packer_if;
    import aes_pkg::*;

    logic [7:0]                in_data;
    logic                      in_valid;
    logic                      in_last;
    logic                      in_ready;

    logic [AES_BLOCK_BITS-1:0] blk_data;
    logic                      blk_valid;
    logic                      blk_ready;
    logic                      blk_last;
    logic [4:0]                blk_nbytes;

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready,
        output blk_data,
        output blk_valid,
        input  blk_ready,
        output blk_last,
        output blk_nbytes
    );

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready,
        input  blk_data,
        input  blk_valid,
        output blk_ready,
        input  blk_last,
        input  blk_nbytes
    );

endinterface

// File: rtl/aes_pad_fill.sv
// rtl/aes_pad_fill.sv - fills the unused tail of a partially assembled block
//
// Macro: AES_PKCS7_EN selects PKCS#7 fill (pad length) instead of 0x00 fill.
// Ports:
//   asm_data[127:0] in  : block with bytes 0..last_idx valid, rest don't-care
//   last_idx[3:0]   in  : index of the last message byte in the block
//   padded[127:0]   out : block with bytes last_idx+1..15 replaced by fill
module aes_pad_fill
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_BITS-1:0] asm_data,
    input  logic [3:0]                last_idx,
    output logic [AES_BLOCK_BITS-1:0] padded
);

    logic [7:0] fill;

    always_comb begin
`ifdef AES_PKCS7_EN
        // PKCS#7: every pad byte carries the pad length, 16-(last_idx+1).
        fill = {4'h0, 4'd15 - last_idx};
`else
        fill = 8'h00;
`endif
        padded = asm_data;
        for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
            if (4'(i) > last_idx) begin
                padded[AES_BLOCK_BITS-1-8*i -: 8] = fill;
            end
        end
    end

endmodule

// File: rtl/aes_byte_packer.sv
// rtl/aes_byte_packer.sv - packs a byte stream into padded 128-bit AES blocks
//
// Macro: AES_PKCS7_EN enables PKCS#7 padding, including the extra all-0x10
//        block for messages that end exactly on a block boundary.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : aes_byte_packer_if.slave
//         in_*  byte stream in (valid/ready, in_last marks final byte)
//         blk_* one-deep output slot (valid/ready, blk_last, blk_nbytes 0..16)
module aes_byte_packer
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    aes_byte_packer_if.slave  bus
);

    packer_state_t             state_q;
    packer_state_t             state_d;

    logic [3:0]                cnt_q;
    logic [AES_BLOCK_BITS-1:0] asm_q;

    logic [AES_BLOCK_BITS-1:0] blk_data_q;
    logic                      blk_valid_q;
    logic                      blk_last_q;
    logic [4:0]                blk_nbytes_q;

    logic                      slot_free;
    logic                      in_ready_c;
    logic                      accept;
    logic                      complete;
    logic                      pad_load;
    logic                      load;
    logic                      load_last;
    logic [AES_BLOCK_BITS-1:0] load_data;
    logic [4:0]                load_nbytes;

    logic [AES_BLOCK_BITS-1:0] merged;
    logic [AES_BLOCK_BITS-1:0] padded;

    // The slot can take a new block if it is empty or is being drained this
    // cycle; this is what makes the blk_ready -> in_ready path combinational.
    assign slot_free  = !blk_valid_q || bus.blk_ready;
    assign in_ready_c = !rst && (state_q == FILL) && slot_free;
    assign accept     = bus.in_valid && in_ready_c;
    assign complete   = accept && ((cnt_q == 4'd15) || bus.in_last);

    // Assembly content with the incoming byte placed in its lane.
    always_comb begin
        merged = asm_q;
        merged[lane_lsb(cnt_q) +: 8] = bus.in_data;
    end

    aes_pad_fill u_pad_fill (
        .asm_data (merged),
        .last_idx (cnt_q),
        .padded   (padded)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and pad-block load strobe.
    always_comb begin
        state_d  = state_q;
        pad_load = 1'b0;
        case (state_q)
            FILL: begin
`ifdef AES_PKCS7_EN
                if (complete && bus.in_last && (cnt_q == 4'd15)) begin
                    state_d = PADBLK;
                end
`endif
            end
`ifdef AES_PKCS7_EN
            PADBLK: begin
                if (slot_free) begin
                    pad_load = 1'b1;
                    state_d  = FILL;
                end
            end
`endif
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Block to place in the output slot.
    always_comb begin
        load = complete || pad_load;
        if (pad_load) begin
            load_data   = {AES_BLOCK_BYTES{AES_PAD_FULL}};
            load_nbytes = 5'd0;
            load_last   = 1'b1;
        end else begin
            load_data   = padded;
            load_nbytes = {1'b0, cnt_q} + 5'd1;
`ifdef AES_PKCS7_EN
            // A boundary-ending message is finished by the pad block instead.
            load_last   = bus.in_last && (cnt_q != 4'd15);
`else
            load_last   = bus.in_last;
`endif
        end
    end

    // Byte assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
            asm_q <= '0;
        end else if (accept) begin
            if (complete) begin
                cnt_q <= 4'd0;
                asm_q <= '0;
            end else begin
                cnt_q <= cnt_q + 4'd1;
                asm_q <= merged;
            end
        end
    end

    // Output slot: a load always wins, so a same-cycle drain and load keeps
    // blk_valid high with no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_data_q   <= '0;
            blk_valid_q  <= 1'b0;
            blk_last_q   <= 1'b0;
            blk_nbytes_q <= 5'd0;
        end else if (load) begin
            blk_data_q   <= load_data;
            blk_valid_q  <= 1'b1;
            blk_last_q   <= load_last;
            blk_nbytes_q <= load_nbytes;
        end else if (blk_valid_q && bus.blk_ready) begin
            blk_valid_q  <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.blk_data   = blk_data_q;
    assign bus.blk_valid  = blk_valid_q;
    assign bus.blk_last   = blk_last_q;
    assign bus.blk_nbytes = blk_nbytes_q;

endmodule

// File: tb/tb_aes_byte_packer.sv
// tb/tb_aes_byte_packer.sv - self-checking bench for aes_byte_packer
module tb_aes_byte_packer;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   passed;

    aes_byte_packer_if bus ();

    aes_byte_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] q_data[$];
    logic         q_last[$];
    logic [4:0]   q_nb[$];
    int           q_cyc[$];

    // Block monitor: sampled mid-cycle, records every output handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.blk_valid && bus.blk_ready) begin
                q_data.push_back(bus.blk_data);
                q_last.push_back(bus.blk_last);
                q_nb.push_back(bus.blk_nbytes);
                q_cyc.push_back(cyc);
            end
        end
    end

    localparam logic [127:0] PAD_BLK = {16{8'h10}};

    typedef struct {
        int           len;
        logic [7:0]   start;
        logic [7:0]   step;
        logic [127:0] exp_data;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, need %h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, output int acc_cyc);
        @(negedge clk);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        acc_cyc = -1;
        for (int n = 0; n < 200; n++) begin
            #2;
            if (bus.in_ready) begin
                acc_cyc = cyc;
                @(posedge clk);
                return;
            end
            @(negedge clk);
        end
        total++;
        $display("FAIL send_timeout: got no in_ready, need in_ready within 200 cycles");
    endtask

    task automatic send_msg(input int len, input logic [7:0] start, input logic [7:0] step,
                            input logic do_last, output int first_acc, output int last_acc);
        int a;
        first_acc = -1;
        last_acc  = -1;
        for (int k = 0; k < len; k++) begin
            send_byte(start + 8'(k) * step, do_last && (k == len - 1), a);
            if (k == 0) first_acc = a;
            last_acc = a;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic expect_blk(input string name, input logic [127:0] ed, input logic el,
                              input logic [4:0] en, output int bcyc);
        bcyc = -1;
        for (int n = 0; n < 100 && q_data.size() == 0; n++) begin
            @(negedge clk);
            #3;
        end
        if (q_data.size() == 0) begin
            total++;
            $display("FAIL %s_timeout: got no block, need a block within 100 cycles", name);
            return;
        end
        check({name, "_data"}, q_data.pop_front(), ed);
        check({name, "_last"}, 128'(q_last.pop_front()), 128'(el));
        check({name, "_nbytes"}, 128'(q_nb.pop_front()), 128'(en));
        bcyc = q_cyc.pop_front();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_in_ready"}, 128'(bus.in_ready), 128'(0));
        check({name, "_blk_valid"}, 128'(bus.blk_valid), 128'(0));
        check({name, "_blk_data"}, bus.blk_data, 128'(0));
        check({name, "_blk_last"}, 128'(bus.blk_last), 128'(0));
        check({name, "_blk_nbytes"}, 128'(bus.blk_nbytes), 128'(0));
    endtask

    initial begin
        int fa, la, c1, c2, bad;
        logic boundary_last;
        total  = 0;
        passed = 0;

`ifdef AES_PKCS7_EN
        boundary_last = 1'b0;
        vecs[0] = '{5,  8'hAA, 8'h00, 128'hAA_AA_AA_AA_AA_0B_0B_0B_0B_0B_0B_0B_0B_0B_0B_0B};
        vecs[1] = '{1,  8'h5C, 8'h00, 128'h5C_0F_0F_0F_0F_0F_0F_0F_0F_0F_0F_0F_0F_0F_0F_0F};
        vecs[2] = '{15, 8'h10, 8'h01, 128'h10_11_12_13_14_15_16_17_18_19_1A_1B_1C_1D_1E_01};
        vecs[3] = '{8,  8'hF0, 8'h01, 128'hF0_F1_F2_F3_F4_F5_F6_F7_08_08_08_08_08_08_08_08};
`else
        boundary_last = 1'b1;
        vecs[0] = '{5,  8'hAA, 8'h00, 128'hAA_AA_AA_AA_AA_00_00_00_00_00_00_00_00_00_00_00};
        vecs[1] = '{1,  8'h5C, 8'h00, 128'h5C_00_00_00_00_00_00_00_00_00_00_00_00_00_00_00};
        vecs[2] = '{15, 8'h10, 8'h01, 128'h10_11_12_13_14_15_16_17_18_19_1A_1B_1C_1D_1E_00};
        vecs[3] = '{8,  8'hF0, 8'h01, 128'hF0_F1_F2_F3_F4_F5_F6_F7_00_00_00_00_00_00_00_00};
`endif

        // Reset state.
        rst           = 1'b1;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.blk_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("ready_after_release", 128'(bus.in_ready), 128'(1));

        // 16 bytes 0x00..0x0F with in_last: latency and boundary handling.
        send_msg(16, 8'h00, 8'h01, 1'b1, fa, la);
        idle();
        #2;
        check("t1_valid_next_cycle", 128'(bus.blk_valid), 128'(1));
        check("t1_in_ready_after", 128'(bus.in_ready), 128'(boundary_last));
        expect_blk("t1", 128'h000102030405060708090A0B0C0D0E0F, boundary_last, 5'd16, c1);
        check("t1_latency", 128'(c1), 128'(la + 1));
`ifdef AES_PKCS7_EN
        expect_blk("t1_pad", PAD_BLK, 1'b1, 5'd0, c2);
        check("t1_pad_cycle", 128'(c2), 128'(la + 2));
`endif

        // Table of single-block messages with partial fill.
        for (int v = 0; v < 4; v++) begin
            send_msg(vecs[v].len, vecs[v].start, vecs[v].step, 1'b1, fa, la);
            idle();
            expect_blk($sformatf("vec%0d", v), vecs[v].exp_data, 1'b1, 5'(vecs[v].len), c1);
        end

        // Backpressure: first block held for 20 cycles with a byte waiting.
        @(negedge clk);
        bus.blk_ready = 1'b0;
        send_msg(16, 8'h20, 8'h01, 1'b0, fa, la);
        @(negedge clk);
        bus.in_data  = 8'h30;
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b0;
        bad = 0;
        repeat (20) begin
            #2;
            if (bus.in_ready || !bus.blk_valid ||
                bus.blk_data !== 128'h202122232425262728292A2B2C2D2E2F) bad++;
            @(negedge clk);
        end
        check("bp_hold_violations", 128'(bad), 128'(0));
        bus.blk_ready = 1'b1;
        #2;
        check("bp_ready_on_release", 128'(bus.in_ready), 128'(1));
        @(posedge clk);
        send_msg(15, 8'h31, 8'h01, 1'b1, fa, la);
        idle();
        expect_blk("bp_b1", 128'h202122232425262728292A2B2C2D2E2F, 1'b0, 5'd16, c1);
        expect_blk("bp_b2", 128'h303132333435363738393A3B3C3D3E3F, boundary_last, 5'd16, c2);
`ifdef AES_PKCS7_EN
        expect_blk("bp_pad", PAD_BLK, 1'b1, 5'd0, c2);
`endif

        // Throughput: 32 bytes back-to-back.
        send_msg(32, 8'h40, 8'h01, 1'b1, fa, la);
        idle();
        check("tp_accept_span", 128'(la - fa), 128'(31));
        expect_blk("tp_b1", 128'h404142434445464748494A4B4C4D4E4F, 1'b0, 5'd16, c1);
        expect_blk("tp_b2", 128'h505152535455565758595A5B5C5D5E5F, boundary_last, 5'd16, c2);
        check("tp_block_spacing", 128'(c2 - c1), 128'(16));
`ifdef AES_PKCS7_EN
        expect_blk("tp_pad", PAD_BLK, 1'b1, 5'd0, c2);
`endif

        // Reset after 7 bytes of a block.
        send_msg(7, 8'h70, 8'h01, 1'b0, fa, la);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #2;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        send_msg(16, 8'h80, 8'h01, 1'b1, fa, la);
        idle();
        expect_blk("rst_fresh", 128'h808182838485868788898A8B8C8D8E8F, boundary_last, 5'd16, c1);
`ifdef AES_PKCS7_EN
        expect_blk("rst_pad", PAD_BLK, 1'b1, 5'd0, c2);
`endif

        repeat (10) @(negedge clk);
        check("no_extra_blocks", 128'(q_data.size()), 128'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
